// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, IF/ID bundle and fetch FSM state for the MIPS pipeline
package cpu_pkg;

    localparam logic [31:0] PC_RESET_VALUE   = 32'h0000_3000;
    localparam logic [31:0] IMEM_BASE_VALUE  = 32'h0000_3000;
    localparam int unsigned IMEM_BYTES_VALUE = 16384;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        adel;
    } if_id_t;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc    = 32'h0;
        b.instr = NOP_INSTR;
        b.valid = 1'b0;
        b.adel  = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register; clear (bubble) wins over load, otherwise holds
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   load,
    input  logic   clear,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= if_id_bubble();
        end else if (clear) begin
            q <= if_id_bubble();
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS IF stage: PC, imem fetch, one-entry stall hold buffer, IF/ID load
// Optional fetch-address check enabled by defining IF_FETCH_ADDR_CHECK_EN.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_VALUE,
    parameter logic [31:0] IMEM_BASE  = IMEM_BASE_VALUE,
    parameter int unsigned IMEM_BYTES = IMEM_BYTES_VALUE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] if_pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        fetch_busy,
    output logic        id_adel
);

    fetch_state_t state, next_state;
    logic [31:0]  pc;
    if_id_t       hold_entry;
    if_id_t       fetch_entry;
    if_id_t       reg_d;
    if_id_t       reg_q;
    logic         pc_load;
    logic         reg_load;
    logic         reg_clear;
    logic         hold_load;
    logic         illegal;
    logic         eff_ready;

`ifdef IF_FETCH_ADDR_CHECK_EN
    localparam logic [32:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + 33'(IMEM_BYTES);
    assign illegal = (pc[1:0] != 2'b00) || (pc < IMEM_BASE) || ({1'b0, pc} >= IMEM_LIMIT);
`else
    assign illegal = 1'b0;
`endif

    // An illegal fetch never touches memory; it completes at once carrying the error flag.
    assign eff_ready         = imem_ready || illegal;
    assign fetch_entry.pc    = pc;
    assign fetch_entry.instr = illegal ? NOP_INSTR : imem_rdata;
    assign fetch_entry.valid = 1'b1;
    assign fetch_entry.adel  = illegal;

    assign if_pc      = pc;
    assign imem_addr  = pc;
    assign imem_req   = (state == FETCH) && !illegal;
    assign fetch_busy = (state == FETCH) && !eff_ready;

    always_comb begin
        next_state = state;
        pc_load    = 1'b0;
        reg_load   = 1'b0;
        reg_clear  = 1'b0;
        hold_load  = 1'b0;
        reg_d      = fetch_entry;
        if (flush) begin
            reg_clear  = 1'b1;
            pc_load    = 1'b1;
            next_state = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (eff_ready && !stall) begin
                        reg_load = 1'b1;
                        pc_load  = 1'b1;
                    end else if (eff_ready && stall) begin
                        hold_load  = 1'b1;
                        next_state = HOLD;
                    end else if (!eff_ready && !stall) begin
                        reg_clear = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        reg_d      = hold_entry;
                        reg_load   = 1'b1;
                        pc_load    = 1'b1;
                        next_state = FETCH;
                    end
                end
                default: next_state = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            pc         <= PC_RESET;
            hold_entry <= if_id_bubble();
        end else begin
            state <= next_state;
            if (pc_load) begin
                pc <= npc;
            end
            if (flush) begin
                hold_entry <= if_id_bubble();
            end else if (hold_load) begin
                hold_entry <= fetch_entry;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (reg_load),
        .clear   (reg_clear),
        .d       (reg_d),
        .q       (reg_q)
    );

    assign id_pc    = reg_q.pc;
    assign id_instr = reg_q.instr;
    assign id_valid = reg_q.valid;
    assign id_adel  = reg_q.adel;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage with directed vectors
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_pc;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        fetch_busy;
    logic        id_adel;

    logic        use_ovr;
    logic [31:0] npc_ovr;

    typedef struct {
        logic [31:0] if_pc;
        logic [31:0] id_pc;
        logic [31:0] id_instr;
        logic        id_valid;
        logic        imem_req;
        logic        fetch_busy;
        logic        id_adel;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Memory returns a recognisable word derived from the address; NPC is pc+4 unless redirected.
    assign imem_rdata = {16'hA5A5, imem_addr[15:0]};
    assign npc        = use_ovr ? npc_ovr : if_pc + 32'd4;

    if_fetch_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .npc        (npc),
        .stall      (stall),
        .flush      (flush),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .if_pc      (if_pc),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_valid   (id_valid),
        .fetch_busy (fetch_busy),
        .id_adel    (id_adel)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("if_pc",      if_pc,             e.if_pc);
                chk("imem_addr",  imem_addr,         e.if_pc);
                chk("id_pc",      id_pc,             e.id_pc);
                chk("id_instr",   id_instr,          e.id_instr);
                chk("id_valid",   32'(id_valid),     32'(e.id_valid));
                chk("imem_req",   32'(imem_req),     32'(e.imem_req));
                chk("fetch_busy", 32'(fetch_busy),   32'(e.fetch_busy));
                chk("id_adel",    32'(id_adel),      32'(e.id_adel));
            end
        end
    end

    // Drive one cycle of inputs just after the sampling edge and queue the outputs
    // expected at the next sampling edge (after the intervening rising edge).
    task automatic step(input logic rst, input logic st, input logic fl, input logic rdy,
                        input logic ovr, input logic [31:0] ovr_pc,
                        input logic [31:0] e_if_pc, input logic [31:0] e_id_pc,
                        input logic [31:0] e_instr, input logic e_valid,
                        input logic e_req, input logic e_busy, input logic e_adel);
        exp_t e;
        @(negedge clk);
        #1;
        reset_n    = rst;
        stall      = st;
        flush      = fl;
        imem_ready = rdy;
        use_ovr    = ovr;
        npc_ovr    = ovr_pc;
        e.if_pc      = e_if_pc;
        e.id_pc      = e_id_pc;
        e.id_instr   = e_instr;
        e.id_valid   = e_valid;
        e.imem_req   = e_req;
        e.fetch_busy = e_busy;
        e.id_adel    = e_adel;
        exp_q.push_back(e);
    endtask

    initial begin : stimulus
        int guard;
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ready = 1'b1;
        use_ovr = 1'b0; npc_ovr = 32'h0;
        //    rst st fl rdy ovr npc_ovr        if_pc         id_pc         id_instr      v req busy adel
        step(0, 0, 0, 1, 0, 32'h0,         32'h0000_3000, 32'h0,         32'h0,         0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 32'h0,         32'h0000_3004, 32'h0000_3000, 32'hA5A5_3000, 1, 1, 0, 0);
        step(1, 0, 0, 1, 0, 32'h0,         32'h0000_3008, 32'h0000_3004, 32'hA5A5_3004, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0, 32'h0,         32'h0000_3008, 32'h0000_3004, 32'hA5A5_3004, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0, 32'h0,         32'h0000_3008, 32'h0000_3004, 32'hA5A5_3004, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0, 32'h0,         32'h0000_3008, 32'h0000_3004, 32'hA5A5_3004, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 32'h0,         32'h0000_300C, 32'h0000_3008, 32'hA5A5_3008, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 32'h0,         32'h0000_300C, 32'h0,         32'h0,         0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 32'h0,         32'h0000_300C, 32'h0,         32'h0,         0, 1, 1, 0);
        step(1, 0, 0, 1, 0, 32'h0,         32'h0000_3010, 32'h0000_300C, 32'hA5A5_300C, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0, 32'h0,         32'h0000_3010, 32'h0000_300C, 32'hA5A5_300C, 1, 0, 0, 0);
        step(1, 1, 1, 1, 1, 32'h0000_4180, 32'h0000_4180, 32'h0,         32'h0,         0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 32'h0,         32'h0000_4184, 32'h0000_4180, 32'hA5A5_4180, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0, 32'h0,         32'h0000_4184, 32'h0000_4180, 32'hA5A5_4180, 1, 0, 0, 0);
        // Async reset lands between the rising edge and the sample, so no clock edge follows it.
        step(1, 1, 0, 1, 0, 32'h0,         32'h0000_3000, 32'h0,         32'h0,         0, 1, 0, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        step(1, 0, 0, 1, 0, 32'h0,         32'h0000_3004, 32'h0000_3000, 32'hA5A5_3000, 1, 1, 0, 0);
        step(1, 0, 1, 0, 1, 32'h0000_5000, 32'h0000_5000, 32'h0,         32'h0,         0, 1, 1, 0);
        step(1, 0, 0, 1, 0, 32'h0,         32'h0000_5004, 32'h0000_5000, 32'hA5A5_5000, 1, 1, 0, 0);
`ifdef IF_FETCH_ADDR_CHECK_EN
        step(1, 0, 0, 1, 1, 32'h0000_3002, 32'h0000_3002, 32'h0000_5004, 32'hA5A5_5004, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h0000_3008, 32'h0000_3008, 32'h0000_3002, 32'h0,         1, 1, 1, 1);
        step(1, 0, 0, 1, 0, 32'h0,         32'h0000_300C, 32'h0000_3008, 32'hA5A5_3008, 1, 1, 0, 0);
`endif
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline. Holds the architectural PC, drives the instruction-memory fetch and loads the IF/ID pipeline register.
- Consumes the next-PC value produced by the NPC block. Returns the current PC as that block's IF_PC operand.
- A one-entry hold buffer keeps an instruction fetched during a stall, so it is never refetched.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address (used only by the optional feature).
- IMEM_BYTES, 16384, size of the legal fetch window in bytes (optional feature).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- npc  in  32  next PC from NPC block; sampled when the PC advances.
- stall  in  1  hazard-unit stall; freezes PC and IF/ID.
- flush  in  1  kills IF/ID contents and the hold buffer; overrides stall.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory has returned data for imem_addr this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals if_pc.
- if_pc  out  32  current PC, fed to NPC as IF_PC.
- id_pc  out  32  PC of the instruction in IF/ID.
- id_instr  out  32  instruction in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_busy  out  1  IF is waiting on memory; the hazard unit ORs it into the stall.
- id_adel  out  1  fetch address error flag (optional feature; otherwise tied 0).

Behaviour:
- Reset (async, reset_n=0):
  - pc=PC_RESET; id_pc=0; id_instr=0; id_valid=0; id_adel=0.
  - Hold buffer cleared; state=FETCH.
- Output decodes:
  - imem_addr=if_pc=pc.
  - imem_req=(state==FETCH).
  - fetch_busy=(state==FETCH && !imem_ready).
- FSM states: FETCH, HOLD.
- FETCH, imem_ready=1, stall=0:
  - IF/ID <= {pc, imem_rdata, valid=1}.
  - pc <= npc; stay in FETCH.
  - Throughput is 1 instruction/cycle.
- FETCH, imem_ready=1, stall=1:
  - hold_instr <= imem_rdata, hold_pc <= pc.
  - pc and IF/ID unchanged; go to HOLD.
- FETCH, imem_ready=0, stall=0:
  - IF/ID <= bubble (pc 0, instr 0, valid 0); pc unchanged.
- FETCH, imem_ready=0, stall=1: everything unchanged.
- HOLD, stall=1: everything unchanged; imem_req=0.
- HOLD, stall=0:
  - IF/ID <= {hold_pc, hold_instr, 1}.
  - pc <= npc; go to FETCH.
- flush=1, any state, highest priority after reset:
  - IF/ID <= bubble; hold buffer discarded; state <= FETCH.
  - pc <= npc, since the redirect target is presented on npc in the same cycle.
  - Applies even when stall=1 or imem_ready=0.
- Ordering of npc sampling: NPC computes IF_PC+4 from the current pc combinationally. pc is only ever loaded from npc, never incremented locally.
- Arithmetic: none internal; pc is a plain 32-bit register with no wrap handling beyond 32-bit truncation.
- Delay slot: the MIPS delay-slot instruction is fetched normally and never killed by a branch. flush is used only for exception/redirect kills.

Optional Feature:
- Macro: IF_FETCH_ADDR_CHECK_EN.
- Defined:
  - A fetch is illegal if pc[1:0]!=0, pc<IMEM_BASE, or pc>=IMEM_BASE+IMEM_BYTES.
  - On an illegal fetch in FETCH: imem_req=0, and imem_ready is treated as 1.
  - IF/ID <= {pc, 32'h0, valid=1}, with id_adel=1.
  - Stall, HOLD and flush rules are unchanged; id_adel travels with the held entry.
- Not defined: no check is made and id_adel is constant 0.

Decomposition:
- Shared package (cpu_pkg):
  - PC_RESET value.
  - IMEM window constants.
  - IF/ID bundle typedef {pc, instr, valid, adel}.
  - FSM state enum {FETCH, HOLD}.
  - NOP/bubble constant 32'h0.
- Sub-module if_id_reg: the IF/ID register with load/hold/flush controls. The FSM and PC stay in the top module.

Test Plan:
- Reset, then imem_ready=1 and npc=if_pc+4 each cycle -> if_pc 0x3000, 0x3004, 0x3008; id_pc lags by one cycle with id_valid=1.
- stall=1 for 3 cycles while imem_ready=1 at pc 0x3008 -> state HOLD, imem_req=0; on release id_instr equals the word at 0x3008 and pc advances exactly once.
- imem_ready=0 for 2 cycles -> fetch_busy=1, id_valid=0 bubbles, pc stays 0x300C; ready=1 resumes normally.
- flush=1 with stall=1 in HOLD and npc=0x4180 -> next cycle id_valid=0, state FETCH, if_pc=0x4180.
- Async reset asserted mid-HOLD (between clock edges) -> outputs return to reset values immediately.
- IF_FETCH_ADDR_CHECK_EN defined, npc=0x3002 -> no imem_req; next IF/ID has id_adel=1, id_instr=0, id_pc=0x3002.
